lsu_mem_access: RTL and testbench
=================================

// Module: lsu_mem_access
// PURPOSE
//   Load/store unit between the MEM pipeline stage and the data port of the dual-port RAM.
//   Turns byte, halfword and word loads/stores into the RAM's word-only, big-endian accesses.
//   Sub-word stores use read-modify-write; loads are lane-extracted and sign/zero-extended.
//   Misaligned accesses are flagged instead of being issued to memory.
// PARAMETERS
//   ADDR_W   32   byte-address width (matches `ADDR_WIDTH)
//   DATA_W   32   data width (fixed 32; other values unsupported)
//   TAG_W    5    width of destination-register tag passed through to the response
// PORTS
//   clk_in           in   1       clock; all state updates on posedge
//   rst_n_in         in   1       synchronous reset, active-low
//   req_valid_in     in   1       MEM-stage request valid
//   req_ready_out    out  1       unit can accept a request this cycle
//   req_we_in        in   1       1 = store, 0 = load
//   req_size_in      in   2       00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_in  in   1       load: 1 = zero-extend, 0 = sign-extend
//   req_addr_in      in   ADDR_W  byte address
//   req_wdata_in     in   DATA_W  store data, value in low bits (byte [7:0], half [15:0])
//   req_tag_in       in   TAG_W   destination tag
//   resp_valid_out   out  1       one-cycle completion pulse, no backpressure
//   resp_rdata_out   out  DATA_W  extended load data; 0 for stores and errors
//   resp_tag_out     out  TAG_W   tag of the completed request
//   resp_err_out     out  1       misaligned or illegal-size request
//   ram_ce_out       out  1       RAM data-port chip enable, active-high
//   ram_we_out       out  1       RAM write enable, active-high
//   ram_addr_out     out  ADDR_W  word-aligned RAM address {addr[ADDR_W-1:2],2'b00}
//   ram_wdata_out    out  DATA_W  word written to RAM
//   ram_rdata_in     in   DATA_W  RAM read data, combinational from ram_addr_out
// BEHAVIOUR
//   Reset
//   - rst_n_in=0 at a posedge sets: state IDLE; resp_valid_out, resp_rdata_out, resp_tag_out, resp_err_out = 0.
//   - While rst_n_in=0: req_ready_out, ram_ce_out and ram_we_out are forced to 0 combinationally,
//     so no RAM write commits in that cycle.
//   Byte lanes (big-endian)
//   - Byte offset 0..3 maps to [31:24], [23:16], [15:8], [7:0].
//   - Half offset 0 maps to [31:16]; offset 2 maps to [15:0].
//   Alignment
//   - Half requires addr[0]=0; word requires addr[1:0]=0.
//   - size 11 is always illegal.
//   States
//   - IDLE: req_ready_out=1. On req_valid_in, latch we/size/unsigned/addr/wdata/tag, then go to:
//     ERR if misaligned or illegal; RD if load; WR if word store; RMW_RD if sub-word store.
//   - RD: ce=1, we=0. Extract and extend the lane from ram_rdata_in into resp regs; set resp_valid; go to IDLE.
//   - RMW_RD: ce=1, we=0. Merge buffer <= ram_rdata_in with the addressed lane replaced by wdata; go to WR.
//   - WR: ce=1, we=1, ram_wdata_out = latched wdata (word store) or merge buffer.
//     RAM writes at this posedge; set resp_valid with rdata=0; go to IDLE.
//   - ERR: ce=0. Set resp_valid with err=1 and rdata=0; go to IDLE.
//   Outputs outside RD/RMW_RD/WR
//   - ram_ce_out=0, ram_we_out=0, ram_addr_out=0, ram_wdata_out=0.
//   - In RD, RMW_RD and WR, ram_addr_out is the latched word-aligned address.
//   Timing
//   - resp_valid_out is high exactly one cycle, the cycle after RD/WR/ERR, and is otherwise 0.
//   - resp data, tag and err hold their values until the next response.
//   - Latency from accept edge to resp_valid: 2 cycles for load, word store and error; 3 cycles for sub-word store.
//   - A new request may be accepted in the same cycle that resp_valid_out is high (back-to-back).
//   - req_valid_in while not ready is ignored; the MEM stage must hold the request until accepted.
//   Reset mid-operation
//   - Any state returns to IDLE, and the latched request is dropped with no response.
//   - If reset occurs during WR, no write commits; an RMW in progress leaves RAM unchanged.
// TESTING
//   1. Hold rst_n_in=0 3 cycles with req_valid_in=1 -> ready=0, ce=0, we=0, resp_* = 0; IDLE after release.
//   2. Word store 0xDEADBEEF @0x100, then word load @0x100 -> rdata 0xDEADBEEF, tag echoed, resp 2 cycles after accept.
//   3. Word 0x11223344 @0x100; byte store 0xA5 @0x101 -> RAM word 0x11A53344, resp 3 cycles after accept.
//      Then signed byte load @0x101 -> 0xFFFFFFA5; unsigned -> 0x000000A5.
//   4. Half store 0x8001 @0x102 -> word 0x11A58001; signed half load @0x102 -> 0xFFFF8001; unsigned @0x100 -> 0x000011A5.
//   5. Word load @0x102, half load @0x103, size=11 @0x100 -> each gives err=1, rdata=0; ram_ce_out never asserted.
//   6. Byte store to 0x100 with rst_n_in dropped during RMW_RD; repeat with reset dropped during WR
//      -> RAM word unchanged both times, no resp_valid pulse, state IDLE.

Source files
------------

// File: rtl/lsu_mem_access.sv
// Load/store unit: maps byte/half/word accesses onto a word-only, big-endian RAM data port.
// Sub-word stores use read-modify-write; misaligned or illegal-size requests complete with an error.
module lsu_mem_access #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              req_valid_in,
  output logic              req_ready_out,
  input  logic              req_we_in,
  input  logic [1:0]        req_size_in,
  input  logic              req_unsigned_in,
  input  logic [ADDR_W-1:0] req_addr_in,
  input  logic [DATA_W-1:0] req_wdata_in,
  input  logic [TAG_W-1:0]  req_tag_in,
  output logic              resp_valid_out,
  output logic [DATA_W-1:0] resp_rdata_out,
  output logic [TAG_W-1:0]  resp_tag_out,
  output logic              resp_err_out,
  output logic              ram_ce_out,
  output logic              ram_we_out,
  output logic [ADDR_W-1:0] ram_addr_out,
  output logic [DATA_W-1:0] ram_wdata_out,
  input  logic [DATA_W-1:0] ram_rdata_in
);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, ERR} state_t;

  state_t            state;
  state_t            state_next;

  logic              lat_unsigned;
  logic [1:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [TAG_W-1:0]  lat_tag;
  logic [DATA_W-1:0] merge_buf;

  logic              accept;
  logic              req_bad;
  logic [ADDR_W-1:0] word_addr;
  logic [DATA_W-1:0] load_value;
  logic [DATA_W-1:0] merged_word;

  // Big-endian lane pick: offset 0 is the most significant byte of the word.
  function automatic logic [31:0] extend_lane(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  offset,
                                              input logic        uns);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] result;
    case (offset)
      2'd0:    lane_b = word[31:24];
      2'd1:    lane_b = word[23:16];
      2'd2:    lane_b = word[15:8];
      default: lane_b = word[7:0];
    endcase
    lane_h = offset[1] ? word[15:0] : word[31:16];
    case (size)
      2'b00:   result = uns ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   result = uns ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: result = word;
    endcase
    return result;
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [15:0] wdata,
                                             input logic [1:0]  size,
                                             input logic [1:0]  offset);
    logic [31:0] result;
    result = word;
    if (size == 2'b00) begin
      case (offset)
        2'd0:    result[31:24] = wdata[7:0];
        2'd1:    result[23:16] = wdata[7:0];
        2'd2:    result[15:8]  = wdata[7:0];
        default: result[7:0]   = wdata[7:0];
      endcase
    end else if (offset[1]) begin
      result[15:0] = wdata;
    end else begin
      result[31:16] = wdata;
    end
    return result;
  endfunction

  assign req_bad = (req_size_in == 2'b11) ||
                   ((req_size_in == 2'b01) && req_addr_in[0]) ||
                   ((req_size_in == 2'b10) && (req_addr_in[1:0] != 2'b00));

  assign accept      = (state == IDLE) && req_valid_in && rst_n_in;
  assign word_addr   = {lat_addr[ADDR_W-1:2], 2'b00};
  assign load_value  = extend_lane(ram_rdata_in, lat_size, lat_addr[1:0], lat_unsigned);
  assign merged_word = merge_lane(ram_rdata_in, lat_wdata[15:0], lat_size, lat_addr[1:0]);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Reset overrides the RAM strobes combinationally so a write in flight never commits.
  always_comb begin
    state_next    = state;
    req_ready_out = 1'b0;
    ram_ce_out    = 1'b0;
    ram_we_out    = 1'b0;
    ram_addr_out  = '0;
    ram_wdata_out = '0;
    case (state)
      IDLE: begin
        req_ready_out = 1'b1;
        if (req_valid_in) begin
          if (req_bad) begin
            state_next = ERR;
          end else if (!req_we_in) begin
            state_next = RD;
          end else if (req_size_in == 2'b10) begin
            state_next = WR;
          end else begin
            state_next = RMW_RD;
          end
        end
      end
      RD: begin
        ram_ce_out   = 1'b1;
        ram_addr_out = word_addr;
        state_next   = IDLE;
      end
      RMW_RD: begin
        ram_ce_out   = 1'b1;
        ram_addr_out = word_addr;
        state_next   = WR;
      end
      WR: begin
        ram_ce_out    = 1'b1;
        ram_we_out    = 1'b1;
        ram_addr_out  = word_addr;
        ram_wdata_out = (lat_size == 2'b10) ? lat_wdata : merge_buf;
        state_next    = IDLE;
      end
      ERR: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (!rst_n_in) begin
      req_ready_out = 1'b0;
      ram_ce_out    = 1'b0;
      ram_we_out    = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      lat_unsigned   <= 1'b0;
      lat_size       <= 2'b00;
      lat_addr       <= '0;
      lat_wdata      <= '0;
      lat_tag        <= '0;
      merge_buf      <= '0;
      resp_valid_out <= 1'b0;
      resp_rdata_out <= '0;
      resp_tag_out   <= '0;
      resp_err_out   <= 1'b0;
    end else begin
      resp_valid_out <= 1'b0;
      if (accept) begin
        lat_unsigned <= req_unsigned_in;
        lat_size     <= req_size_in;
        lat_addr     <= req_addr_in;
        lat_wdata    <= req_wdata_in;
        lat_tag      <= req_tag_in;
      end
      case (state)
        RD: begin
          resp_valid_out <= 1'b1;
          resp_rdata_out <= load_value;
          resp_tag_out   <= lat_tag;
          resp_err_out   <= 1'b0;
        end
        RMW_RD: begin
          merge_buf <= merged_word;
        end
        WR: begin
          resp_valid_out <= 1'b1;
          resp_rdata_out <= '0;
          resp_tag_out   <= lat_tag;
          resp_err_out   <= 1'b0;
        end
        ERR: begin
          resp_valid_out <= 1'b1;
          resp_rdata_out <= '0;
          resp_tag_out   <= lat_tag;
          resp_err_out   <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Bench for lsu_mem_access: a word RAM model on the data port plus a byte-addressed
// big-endian reference memory that predicts load results, RAM contents and latencies.
module tb_lsu_mem_access;

  logic        clk_in;
  logic        rst_n_in;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        req_we_in;
  logic [1:0]  req_size_in;
  logic        req_unsigned_in;
  logic [31:0] req_addr_in;
  logic [31:0] req_wdata_in;
  logic [4:0]  req_tag_in;
  logic        resp_valid_out;
  logic [31:0] resp_rdata_out;
  logic [4:0]  resp_tag_out;
  logic        resp_err_out;
  logic        ram_ce_out;
  logic        ram_we_out;
  logic [31:0] ram_addr_out;
  logic [31:0] ram_wdata_out;
  logic [31:0] ram_rdata_in;

  lsu_mem_access #(.ADDR_W(32), .DATA_W(32), .TAG_W(5)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_we_in(req_we_in), .req_size_in(req_size_in), .req_unsigned_in(req_unsigned_in),
    .req_addr_in(req_addr_in), .req_wdata_in(req_wdata_in), .req_tag_in(req_tag_in),
    .resp_valid_out(resp_valid_out), .resp_rdata_out(resp_rdata_out),
    .resp_tag_out(resp_tag_out), .resp_err_out(resp_err_out),
    .ram_ce_out(ram_ce_out), .ram_we_out(ram_we_out), .ram_addr_out(ram_addr_out),
    .ram_wdata_out(ram_wdata_out), .ram_rdata_in(ram_rdata_in)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass = 0;

  logic [7:0]  ref_mem [0:1023];
  logic [31:0] ram [0:255];
  logic        ram_init;
  int          ce_count = 0;

  assign ram_rdata_in = ram[ram_addr_out[9:2]];

  always @(posedge clk_in) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++)
        ram[i] <= {ref_mem[4*i], ref_mem[4*i+1], ref_mem[4*i+2], ref_mem[4*i+3]};
    end else if (ram_ce_out && ram_we_out) begin
      ram[ram_addr_out[9:2]] <= ram_wdata_out;
    end
    if (ram_ce_out) ce_count <= ce_count + 1;
  end

  function automatic logic [31:0] ref_word(input int addr);
    int b;
    b = addr - (addr % 4);
    return {ref_mem[b], ref_mem[b+1], ref_mem[b+2], ref_mem[b+3]};
  endfunction

  function automatic bit ref_bad(input int addr, input int size);
    if (size == 3) return 1'b1;
    return (addr % (1 << size)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input int addr, input int size, input bit uns);
    int n;
    logic [31:0] v;
    n = 1 << size;
    v = 32'd0;
    for (int i = 0; i < n; i++) v = (v << 8) | {24'd0, ref_mem[addr+i]};
    if (!uns && n < 4 && v[8*n-1]) v = v - (32'd1 << (8*n));
    return v;
  endfunction

  task automatic ref_store(input int addr, input int size, input logic [31:0] wdata);
    int n;
    logic [31:0] t;
    n = 1 << size;
    for (int i = 0; i < n; i++) begin
      t = wdata >> (8*(n-1-i));
      ref_mem[addr+i] = t[7:0];
    end
  endtask

  logic [31:0] r_rdata;
  logic [4:0]  r_tag;
  logic        r_err;
  int          r_lat;
  logic        r_seen;

  // r_lat counts cycles after the accept cycle; 8 means no response arrived.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] tag, input bit b2b);
    int waits;
    if (!b2b) @(negedge clk_in);
    req_valid_in = 1'b1; req_we_in = we; req_size_in = size; req_unsigned_in = uns;
    req_addr_in = addr; req_wdata_in = wdata; req_tag_in = tag;
    waits = 0;
    while (!req_ready_out && waits < 10) begin
      @(negedge clk_in);
      waits++;
    end
    @(negedge clk_in);
    req_valid_in = 1'b0;
    r_seen = 1'b0; r_lat = 1; r_rdata = 32'hBAD0BAD0; r_tag = 5'h1F; r_err = 1'bx;
    while (!r_seen && r_lat < 8) begin
      if (resp_valid_out) begin
        r_seen = 1'b1; r_rdata = resp_rdata_out; r_tag = resp_tag_out; r_err = resp_err_out;
      end else begin
        @(negedge clk_in);
        r_lat++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0; req_valid_in = 1'b1; req_we_in = 1'b1; req_size_in = 2'b10;
    req_unsigned_in = 1'b0; req_addr_in = 32'h100; req_wdata_in = 32'hCAFEF00D; req_tag_in = 5'd9;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_in);
      ram_init = 1'b0;
      n_checks++; if (req_ready_out !== 1'b0) $display("FAIL reset_ready got=%b exp=0", req_ready_out); else n_pass++;
      n_checks++; if (ram_ce_out !== 1'b0) $display("FAIL reset_ce got=%b exp=0", ram_ce_out); else n_pass++;
      n_checks++; if (ram_we_out !== 1'b0) $display("FAIL reset_we got=%b exp=0", ram_we_out); else n_pass++;
      n_checks++; if (resp_valid_out !== 1'b0) $display("FAIL reset_resp_valid got=%b exp=0", resp_valid_out); else n_pass++;
      n_checks++; if (resp_rdata_out !== 32'd0) $display("FAIL reset_resp_rdata got=%h exp=0", resp_rdata_out); else n_pass++;
      n_checks++; if (resp_tag_out !== 5'd0) $display("FAIL reset_resp_tag got=%h exp=0", resp_tag_out); else n_pass++;
      n_checks++; if (resp_err_out !== 1'b0) $display("FAIL reset_resp_err got=%b exp=0", resp_err_out); else n_pass++;
    end
    rst_n_in = 1'b1; req_valid_in = 1'b0;
    @(negedge clk_in);
    n_checks++; if (req_ready_out !== 1'b1) $display("FAIL reset_idle_ready got=%b exp=1", req_ready_out); else n_pass++;
    n_checks++; if (ram[64] !== ref_word(32'h100)) $display("FAIL reset_no_write got=%h exp=%h", ram[64], ref_word(32'h100)); else n_pass++;
  endtask

  task automatic test_word();
    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 5'd3, 1'b0);
    ref_store(32'h100, 2, 32'hDEADBEEF);
    n_checks++; if (r_lat !== 2) $display("FAIL word_store_latency got=%0d exp=2", r_lat); else n_pass++;
    n_checks++; if (r_rdata !== 32'd0 || r_err !== 1'b0) $display("FAIL word_store_resp got=%h/%b exp=0/0", r_rdata, r_err); else n_pass++;
    n_checks++; if (r_tag !== 5'd3) $display("FAIL word_store_tag got=%h exp=3", r_tag); else n_pass++;
    @(negedge clk_in);
    n_checks++; if (resp_valid_out !== 1'b0) $display("FAIL resp_one_cycle got=%b exp=0", resp_valid_out); else n_pass++;
    n_checks++; if (resp_tag_out !== 5'd3) $display("FAIL resp_tag_hold got=%h exp=3", resp_tag_out); else n_pass++;
    n_checks++; if (ram[64] !== 32'hDEADBEEF) $display("FAIL word_store_ram got=%h exp=deadbeef", ram[64]); else n_pass++;
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 5'd7, 1'b0);
    n_checks++; if (r_lat !== 2) $display("FAIL word_load_latency got=%0d exp=2", r_lat); else n_pass++;
    n_checks++; if (r_rdata !== 32'hDEADBEEF) $display("FAIL word_load_rdata got=%h exp=deadbeef", r_rdata); else n_pass++;
    n_checks++; if (r_tag !== 5'd7) $display("FAIL word_load_tag got=%h exp=7", r_tag); else n_pass++;
  endtask

  task automatic test_subword();
    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'h11223344, 5'd1, 1'b0);
    ref_store(32'h100, 2, 32'h11223344);
    issue(1'b1, 2'b00, 1'b0, 32'h101, 32'hFFFFFFA5, 5'd2, 1'b0);
    ref_store(32'h101, 0, 32'hFFFFFFA5);
    n_checks++; if (r_lat !== 3) $display("FAIL byte_store_latency got=%0d exp=3", r_lat); else n_pass++;
    @(negedge clk_in);
    n_checks++; if (ram[64] !== 32'h11A53344) $display("FAIL byte_store_ram got=%h exp=11a53344", ram[64]); else n_pass++;
    issue(1'b0, 2'b00, 1'b0, 32'h101, 32'd0, 5'd4, 1'b0);
    n_checks++; if (r_rdata !== 32'hFFFFFFA5) $display("FAIL byte_load_signed got=%h exp=ffffffa5", r_rdata); else n_pass++;
    issue(1'b0, 2'b00, 1'b1, 32'h101, 32'd0, 5'd5, 1'b0);
    n_checks++; if (r_rdata !== 32'h000000A5) $display("FAIL byte_load_unsigned got=%h exp=000000a5", r_rdata); else n_pass++;
    issue(1'b1, 2'b01, 1'b0, 32'h102, 32'h00008001, 5'd6, 1'b0);
    ref_store(32'h102, 1, 32'h00008001);
    n_checks++; if (r_lat !== 3) $display("FAIL half_store_latency got=%0d exp=3", r_lat); else n_pass++;
    @(negedge clk_in);
    n_checks++; if (ram[64] !== 32'h11A58001) $display("FAIL half_store_ram got=%h exp=11a58001", ram[64]); else n_pass++;
    issue(1'b0, 2'b01, 1'b0, 32'h102, 32'd0, 5'd8, 1'b0);
    n_checks++; if (r_rdata !== 32'hFFFF8001) $display("FAIL half_load_signed got=%h exp=ffff8001", r_rdata); else n_pass++;
    issue(1'b0, 2'b01, 1'b1, 32'h100, 32'd0, 5'd10, 1'b0);
    n_checks++; if (r_rdata !== 32'h000011A5) $display("FAIL half_load_unsigned got=%h exp=000011a5", r_rdata); else n_pass++;
  endtask

  task automatic test_error();
    int ce_before;
    ce_before = ce_count;
    issue(1'b0, 2'b10, 1'b0, 32'h102, 32'd0, 5'd11, 1'b0);
    n_checks++; if (r_err !== 1'b1 || r_rdata !== 32'd0 || r_lat !== 2) $display("FAIL err_word_misaligned got=%b/%h/%0d exp=1/0/2", r_err, r_rdata, r_lat); else n_pass++;
    issue(1'b0, 2'b01, 1'b0, 32'h103, 32'd0, 5'd12, 1'b0);
    n_checks++; if (r_err !== 1'b1 || r_rdata !== 32'd0 || r_lat !== 2) $display("FAIL err_half_misaligned got=%b/%h/%0d exp=1/0/2", r_err, r_rdata, r_lat); else n_pass++;
    issue(1'b0, 2'b11, 1'b0, 32'h100, 32'd0, 5'd13, 1'b0);
    n_checks++; if (r_err !== 1'b1 || r_rdata !== 32'd0 || r_tag !== 5'd13) $display("FAIL err_size11 got=%b/%h/%h exp=1/0/0d", r_err, r_rdata, r_tag); else n_pass++;
    issue(1'b1, 2'b10, 1'b0, 32'h101, 32'h12345678, 5'd14, 1'b0);
    n_checks++; if (r_err !== 1'b1) $display("FAIL err_store_misaligned got=%b exp=1", r_err); else n_pass++;
    @(negedge clk_in);
    n_checks++; if (ce_count !== ce_before) $display("FAIL err_ce_asserted got=%0d exp=%0d", ce_count, ce_before); else n_pass++;
    n_checks++; if (ram[64] !== ref_word(32'h100)) $display("FAIL err_ram_changed got=%h exp=%h", ram[64], ref_word(32'h100)); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic pulse;
    for (int p = 0; p < 2; p++) begin
      @(negedge clk_in);
      req_valid_in = 1'b1; req_we_in = 1'b1; req_size_in = 2'b00; req_unsigned_in = 1'b0;
      req_addr_in = 32'h100; req_wdata_in = 32'h0000005A; req_tag_in = 5'd6;
      @(negedge clk_in);
      req_valid_in = 1'b0;
      if (p == 1) @(negedge clk_in);
      rst_n_in = 1'b0;
      #1;
      n_checks++; if (ram_ce_out !== 1'b0 || ram_we_out !== 1'b0) $display("FAIL midreset_strobes pass=%0d got=%b%b exp=00", p, ram_ce_out, ram_we_out); else n_pass++;
      @(negedge clk_in);
      rst_n_in = 1'b1;
      pulse = resp_valid_out;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk_in);
        if (resp_valid_out) pulse = 1'b1;
      end
      n_checks++; if (pulse !== 1'b0) $display("FAIL midreset_resp pass=%0d got=%b exp=0", p, pulse); else n_pass++;
      n_checks++; if (ram[64] !== ref_word(32'h100)) $display("FAIL midreset_ram pass=%0d got=%h exp=%h", p, ram[64], ref_word(32'h100)); else n_pass++;
      n_checks++; if (req_ready_out !== 1'b1) $display("FAIL midreset_idle pass=%0d got=%b exp=1", p, req_ready_out); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 2'b00, 1'b0, 32'h200, 32'h0000003C, 5'd4, 1'b0);
    ref_store(32'h200, 0, 32'h0000003C);
    n_checks++; if (req_ready_out !== 1'b1 || resp_valid_out !== 1'b1) $display("FAIL b2b_ready_with_resp got=%b%b exp=11", req_ready_out, resp_valid_out); else n_pass++;
    issue(1'b0, 2'b00, 1'b1, 32'h200, 32'd0, 5'd9, 1'b1);
    n_checks++; if (r_lat !== 2) $display("FAIL b2b_latency got=%0d exp=2", r_lat); else n_pass++;
    n_checks++; if (r_rdata !== 32'h0000003C || r_tag !== 5'd9) $display("FAIL b2b_load got=%h/%h exp=0000003c/09", r_rdata, r_tag); else n_pass++;
  endtask

  task automatic test_random();
    int size, addr, exp_lat;
    bit we, uns, bad;
    logic [31:0] wdata, exp_rdata;
    logic [4:0] tag;
    for (int k = 0; k < 60; k++) begin
      size = $urandom_range(0, 3);
      we = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      addr = $urandom_range(0, 1023);
      if ($urandom_range(0, 3) != 0 && size < 3) addr = addr - (addr % (1 << size));
      wdata = $urandom;
      tag = 5'($urandom_range(0, 31));
      bad = ref_bad(addr, size);
      exp_lat = (!bad && we && size < 2) ? 3 : 2;
      exp_rdata = (bad || we) ? 32'd0 : ref_load(addr, size, uns);
      issue(we, 2'(size), uns, 32'(addr), wdata, tag, 1'b0);
      if (!bad && we) ref_store(addr, size, wdata);
      n_checks++; if (r_lat !== exp_lat) $display("FAIL rand_latency op=%0d got=%0d exp=%0d", k, r_lat, exp_lat); else n_pass++;
      n_checks++; if (r_err !== bad) $display("FAIL rand_err op=%0d got=%b exp=%b", k, r_err, bad); else n_pass++;
      n_checks++; if (r_rdata !== exp_rdata) $display("FAIL rand_rdata op=%0d addr=%h size=%0d got=%h exp=%h", k, addr, size, r_rdata, exp_rdata); else n_pass++;
      n_checks++; if (r_tag !== tag) $display("FAIL rand_tag op=%0d got=%h exp=%h", k, r_tag, tag); else n_pass++;
      if (we) begin
        @(negedge clk_in);
        n_checks++; if (ram[addr/4] !== ref_word(addr)) $display("FAIL rand_ram op=%0d addr=%h got=%h exp=%h", k, addr, ram[addr/4], ref_word(addr)); else n_pass++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
    ram_init = 1'b1;
    test_reset();
    test_word();
    test_subword();
    test_error();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
